// File: rtl/tmr_scrub_ctrl.sv
// Purpose: scrub scheduler for triplicated state registers; votes one register per slot and writes back the majority value.
// Latency: a mismatch seen in VOTE raises fix_we exactly one cycle later; a slot lasts SCRUB_PERIOD+1 cycles, or +2 with a fix.
// Backpressure: a functional update to the scrubbed register suppresses the fix; en=0 parks the scheduler in IDLE and holds idx and statistics.
module tmr_scrub_ctrl #(
    parameter int WIDTH        = 1,
    parameter int NREG         = 4,
    parameter int SCRUB_PERIOD = 16,
    localparam int IW          = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int CW          = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic [NREG*WIDTH-1:0]   cp_a,
    input  logic [NREG*WIDTH-1:0]   cp_b,
    input  logic [NREG*WIDTH-1:0]   cp_c,
    input  logic [NREG-1:0]         upd_req,
    output logic                    fix_we,
    output logic [IW-1:0]           fix_idx,
    output logic [WIDTH-1:0]        fix_data,
    output logic                    busy,
    output logic                    scan_done,
    output logic                    err_flag,
    output logic [7:0]              err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_VOTE = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] maj_q, maj_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             err_flag_q, err_flag_d;
    logic             scan_done_q, scan_done_d;
    logic [IW-1:0]    fix_idx_q, fix_idx_d;
    logic [WIDTH-1:0] fix_data_q, fix_data_d;

    logic [WIDTH-1:0] sel_a, sel_b, sel_c;
    logic             sel_upd;
    logic [WIDTH-1:0] maj_now;
    logic             mismatch;
    logic             cnt_done;
    logic             last_idx;
    logic [IW-1:0]    idx_nxt;

    // Pick out the three copies and the functional-update request of the register under scrub
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_c   = '0;
        sel_upd = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (idx_q == IW'(i)) begin
                sel_a   = cp_a[i*WIDTH +: WIDTH];
                sel_b   = cp_b[i*WIDTH +: WIDTH];
                sel_c   = cp_c[i*WIDTH +: WIDTH];
                sel_upd = upd_req[i];
            end
        end
    end

    // Bit-wise majority vote, slot timer terminal count and index wrap
    always_comb begin
        maj_now  = (sel_a & sel_b) | (sel_a & sel_c) | (sel_b & sel_c);
        mismatch = (sel_a != sel_b) || (sel_b != sel_c);
        cnt_done = (cnt_q == CW'(SCRUB_PERIOD - 1));
        last_idx = (idx_q == IW'(NREG - 1));
        idx_nxt  = last_idx ? '0 : idx_q + IW'(1);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: dropping en always parks the scheduler in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (en) state_d = S_WAIT;
            S_WAIT: if (cnt_done) state_d = S_VOTE;
            S_VOTE: state_d = mismatch ? S_FIX : S_WAIT;
            S_FIX:  state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
        if (!en) begin
            state_d = S_IDLE;
        end
    end

    // FSM outputs: the fix strobe yields to a functional write of the same register and to en=0
    always_comb begin
        busy     = (state_q == S_VOTE) || (state_q == S_FIX);
        fix_we   = (state_q == S_FIX) && en && !sel_upd;
        fix_idx  = fix_we ? idx_q : fix_idx_q;
        fix_data = fix_we ? maj_q : fix_data_q;
    end

    // Datapath next values: slot timer, vote capture, error statistics, index advance
    always_comb begin
        cnt_d       = '0;
        idx_d       = idx_q;
        maj_d       = maj_q;
        err_cnt_d   = err_cnt_q;
        err_flag_d  = err_flag_q;
        scan_done_d = 1'b0;
        fix_idx_d   = fix_idx_q;
        fix_data_d  = fix_data_q;
        if (en) begin
            case (state_q)
                S_WAIT: begin
                    cnt_d = cnt_done ? '0 : cnt_q + CW'(1);
                end
                S_VOTE: begin
                    maj_d = maj_now;
                    if (mismatch) begin
                        err_flag_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end else begin
                        idx_d       = idx_nxt;
                        scan_done_d = last_idx;
                    end
                end
                S_FIX: begin
                    if (fix_we) begin
                        fix_idx_d  = idx_q;
                        fix_data_d = maj_q;
                    end
                    idx_d       = idx_nxt;
                    scan_done_d = last_idx;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            maj_q       <= '0;
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            scan_done_q <= 1'b0;
            fix_idx_q   <= '0;
            fix_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            maj_q       <= maj_d;
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
            scan_done_q <= scan_done_d;
            fix_idx_q   <= fix_idx_d;
            fix_data_q  <= fix_data_d;
        end
    end

    assign scan_done = scan_done_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;

endmodule
